// File: rtl/dkong_dma_arb_pkg.sv
// Shared state encoding and default timing constants for the Z80 / sprite-DMA bus arbiter.
// The bench imports this package, so it uses the same timing values as the RTL.
package dkong_dma_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_GRANT = 3'd2,
      ST_REL   = 3'd3,
      ST_GAP   = 3'd4
   } arb_state_t;

   localparam logic [7:0] ACK_TIMEOUT = 8'd255;
   localparam logic [3:0] REL_GAP     = 4'd2;

endpackage

// File: rtl/dkong_dma_arb.sv
// Bus arbiter between the Z80 CPU and the sprite DMA for the shared object RAM.
// Turns DMA HRQ into a BUSRQn/BUSAKn handshake and steers the RAM address to the bus owner.
module dkong_dma_arb
   import dkong_dma_arb_pkg::*;
#(
   parameter logic [7:0] ACK_TO  = ACK_TIMEOUT,
   parameter logic [3:0] REL_GP  = REL_GAP
) (
   input  logic       I_CLK,
   input  logic       I_RST,
   input  logic       I_CLK_EN,
   input  logic       I_DMA_HRQ,
   output logic       O_DMA_HLDA,
   output logic       O_CPU_BUSRQn,
   input  logic       I_CPU_BUSAKn,
   input  logic [9:0] I_CPU_A,
   input  logic       I_CPU_CS,
   input  logic [9:0] I_DMA_AS,
   input  logic       I_DMA_CES,
   output logic [9:0] O_RAM_A,
   output logic       O_RAM_CS,
   output logic       O_BUSY,
   output logic       O_TIMEOUT
);

   arb_state_t state, state_nx;
   logic [7:0] to_cnt, to_cnt_nx;
   logic [3:0] gap_cnt, gap_cnt_nx;
   logic       busrq_nx, hlda_nx, busy_nx, timeout_nx;
   logic       gap_done;
   logic       sel_dma;

   // Wide compare so REL_GP of zero leaves GAP after a single cycle instead of wrapping.
   assign gap_done = ({1'b0, gap_cnt} + 5'd1) >= {1'b0, REL_GP};

   always_comb begin
      state_nx   = state;
      to_cnt_nx  = to_cnt;
      gap_cnt_nx = gap_cnt;
      busrq_nx   = O_CPU_BUSRQn;
      hlda_nx    = O_DMA_HLDA;
      timeout_nx = O_TIMEOUT;
      case (state)
         ST_IDLE: begin
            if (I_DMA_HRQ) begin
               state_nx  = ST_REQ;
               busrq_nx  = 1'b0;
               to_cnt_nx = 8'd0;
            end
         end
         ST_REQ: begin
            // A withdrawn request beats a simultaneous acknowledge.
            if (!I_DMA_HRQ) begin
               state_nx = ST_REL;
               busrq_nx = 1'b1;
            end else if (!I_CPU_BUSAKn) begin
               state_nx = ST_GRANT;
               hlda_nx  = 1'b1;
            end else if (to_cnt == ACK_TO) begin
               state_nx   = ST_REL;
               busrq_nx   = 1'b1;
               timeout_nx = 1'b1;
            end else begin
               to_cnt_nx = to_cnt + 8'd1;
            end
         end
         ST_GRANT: begin
            // CPU taking the bus back mid-grant is treated like a release.
            if (!I_DMA_HRQ || I_CPU_BUSAKn) begin
               state_nx = ST_REL;
               hlda_nx  = 1'b0;
               busrq_nx = 1'b1;
            end
         end
         ST_REL: begin
            if (I_CPU_BUSAKn) begin
               state_nx   = ST_GAP;
               gap_cnt_nx = 4'd0;
            end
         end
         ST_GAP: begin
            if (gap_done) state_nx = ST_IDLE;
            else          gap_cnt_nx = gap_cnt + 4'd1;
         end
         default: begin
            state_nx = ST_IDLE;
            busrq_nx = 1'b1;
            hlda_nx  = 1'b0;
         end
      endcase
      busy_nx = (state_nx != ST_IDLE);
   end

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         state        <= ST_IDLE;
         to_cnt       <= 8'd0;
         gap_cnt      <= 4'd0;
         O_CPU_BUSRQn <= 1'b1;
         O_DMA_HLDA   <= 1'b0;
         O_BUSY       <= 1'b0;
         O_TIMEOUT    <= 1'b0;
      end else if (I_CLK_EN) begin
         state        <= state_nx;
         to_cnt       <= to_cnt_nx;
         gap_cnt      <= gap_cnt_nx;
         O_CPU_BUSRQn <= busrq_nx;
         O_DMA_HLDA   <= hlda_nx;
         O_BUSY       <= busy_nx;
         O_TIMEOUT    <= timeout_nx;
      end
   end

   assign sel_dma  = (state == ST_GRANT);
   assign O_RAM_A  = sel_dma ? I_DMA_AS  : I_CPU_A;
   assign O_RAM_CS = sel_dma ? I_DMA_CES : I_CPU_CS;

endmodule

// File: tb/tb_dkong_dma_arb.sv
// Self-checking bench for dkong_dma_arb: hand-derived vector table, directed corner cases,
// and randomized traffic compared against an ownership-level reference model.
module tb_dkong_dma_arb;
   import dkong_dma_arb_pkg::*;

   logic       I_CLK, I_RST, I_CLK_EN, I_DMA_HRQ, I_CPU_BUSAKn, I_CPU_CS, I_DMA_CES;
   logic [9:0] I_CPU_A, I_DMA_AS, O_RAM_A;
   logic       O_DMA_HLDA, O_CPU_BUSRQn, O_RAM_CS, O_BUSY, O_TIMEOUT;

   int checks = 0;
   int errors = 0;

   // Reference model: who holds the bus, not how the RTL encodes it.
   bit mReq, mGrant, mRel, mTout;
   int mWait, mGapLeft;

   dkong_dma_arb dut (
      .I_CLK(I_CLK), .I_RST(I_RST), .I_CLK_EN(I_CLK_EN),
      .I_DMA_HRQ(I_DMA_HRQ), .O_DMA_HLDA(O_DMA_HLDA),
      .O_CPU_BUSRQn(O_CPU_BUSRQn), .I_CPU_BUSAKn(I_CPU_BUSAKn),
      .I_CPU_A(I_CPU_A), .I_CPU_CS(I_CPU_CS),
      .I_DMA_AS(I_DMA_AS), .I_DMA_CES(I_DMA_CES),
      .O_RAM_A(O_RAM_A), .O_RAM_CS(O_RAM_CS),
      .O_BUSY(O_BUSY), .O_TIMEOUT(O_TIMEOUT)
   );

   initial I_CLK = 1'b0;
   always #5 I_CLK = ~I_CLK;

   typedef struct {
      bit         en;
      bit         hrq;
      bit         busakn;
      bit         busrqn;
      bit         hlda;
      bit         busy;
      bit         cs;
      logic [9:0] ram_a;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mReq = 0; mGrant = 0; mRel = 0; mTout = 0; mWait = 0; mGapLeft = 0;
   endtask

   task automatic modelStep(input bit hrq, input bit busakn);
      if (mGrant) begin
         if (!hrq || busakn) begin mGrant = 0; mRel = 1; end
      end else if (mReq) begin
         if (!hrq) begin
            mReq = 0; mRel = 1;
         end else if (!busakn) begin
            mReq = 0; mGrant = 1;
         end else if (mWait == int'(ACK_TIMEOUT)) begin
            mReq = 0; mRel = 1; mTout = 1;
         end else begin
            mWait++;
         end
      end else if (mRel) begin
         if (busakn) begin mRel = 0; mGapLeft = int'(REL_GAP); end
      end else if (mGapLeft > 0) begin
         mGapLeft--;
      end else if (hrq) begin
         mReq = 1; mWait = 0;
      end
   endtask

   task automatic applyStimulus(input bit en, input bit hrq, input bit busakn);
      I_CLK_EN     = en;
      I_DMA_HRQ    = hrq;
      I_CPU_BUSAKn = busakn;
      @(posedge I_CLK);
      if (en && !I_RST) modelStep(hrq, busakn);
      #1;
   endtask

   task automatic checkModel(input string tag);
      bit own;
      own = mGrant;
      checkOutput({tag, ".busrqn"},  O_CPU_BUSRQn, !(mReq || mGrant));
      checkOutput({tag, ".hlda"},    O_DMA_HLDA,   own);
      checkOutput({tag, ".busy"},    O_BUSY,       mReq || mGrant || mRel || (mGapLeft > 0));
      checkOutput({tag, ".timeout"}, O_TIMEOUT,    mTout);
      checkOutput({tag, ".ram_a"},   O_RAM_A,      own ? I_DMA_AS : I_CPU_A);
      checkOutput({tag, ".ram_cs"},  O_RAM_CS,     own ? I_DMA_CES : I_CPU_CS);
   endtask

   task automatic doReset();
      I_RST = 1'b1;
      #12;
      modelReset();
      @(negedge I_CLK);
      I_RST = 1'b0;
      #1;
   endtask

   initial begin
      vec_t vecs[$];
      bit   sawHlda;
      bit   hrq, ak, en;

      I_RST = 1'b1; I_CLK_EN = 1'b1; I_DMA_HRQ = 1'b0; I_CPU_BUSAKn = 1'b1;
      I_CPU_A = 10'h055; I_CPU_CS = 1'b1; I_DMA_AS = 10'h100; I_DMA_CES = 1'b0;
      doReset();
      checkOutput("reset.busrqn", O_CPU_BUSRQn, 1'b1);
      checkOutput("reset.hlda",   O_DMA_HLDA,   1'b0);
      checkOutput("reset.busy",   O_BUSY,       1'b0);
      checkOutput("reset.tout",   O_TIMEOUT,    1'b0);
      checkOutput("reset.ram_a",  O_RAM_A,      10'h055);

      // Basic grant, release with gap, HRQ held during gap, then a withdraw race.
      //         en hrq ak  rqn hlda busy cs  ram_a
      vecs.push_back('{1, 1, 1,  0, 0, 1, 1, 10'h055});
      vecs.push_back('{1, 1, 1,  0, 0, 1, 1, 10'h055});
      vecs.push_back('{1, 1, 1,  0, 0, 1, 1, 10'h055});
      vecs.push_back('{1, 1, 0,  0, 1, 1, 0, 10'h100});
      vecs.push_back('{1, 1, 0,  0, 1, 1, 0, 10'h100});
      vecs.push_back('{1, 0, 0,  1, 0, 1, 1, 10'h055});
      vecs.push_back('{1, 0, 0,  1, 0, 1, 1, 10'h055});
      vecs.push_back('{1, 0, 1,  1, 0, 1, 1, 10'h055});
      vecs.push_back('{1, 1, 1,  1, 0, 1, 1, 10'h055});
      vecs.push_back('{1, 1, 1,  1, 0, 0, 1, 10'h055});
      vecs.push_back('{1, 1, 1,  0, 0, 1, 1, 10'h055});
      vecs.push_back('{0, 0, 0,  0, 0, 1, 1, 10'h055});
      vecs.push_back('{1, 0, 0,  1, 0, 1, 1, 10'h055});
      vecs.push_back('{1, 0, 1,  1, 0, 1, 1, 10'h055});
      vecs.push_back('{1, 0, 1,  1, 0, 1, 1, 10'h055});
      vecs.push_back('{1, 0, 1,  1, 0, 0, 1, 10'h055});
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].en, vecs[i].hrq, vecs[i].busakn);
         checkOutput($sformatf("vec%0d.busrqn", i), O_CPU_BUSRQn, vecs[i].busrqn);
         checkOutput($sformatf("vec%0d.hlda", i),   O_DMA_HLDA,   vecs[i].hlda);
         checkOutput($sformatf("vec%0d.busy", i),   O_BUSY,       vecs[i].busy);
         checkOutput($sformatf("vec%0d.cs", i),     O_RAM_CS,     vecs[i].cs);
         checkOutput($sformatf("vec%0d.ram_a", i),  O_RAM_A,      vecs[i].ram_a);
      end

      // Timeout: BUSAKn never falls; abort on the 256th enabled cycle in REQ.
      doReset();
      sawHlda = 1'b0;
      applyStimulus(1, 1, 1);
      for (int i = 0; i < 255; i++) begin
         applyStimulus(1, 1, 1);
         sawHlda |= O_DMA_HLDA;
      end
      checkOutput("tout.pre_busrqn", O_CPU_BUSRQn, 1'b0);
      checkOutput("tout.pre_flag",   O_TIMEOUT,    1'b0);
      applyStimulus(1, 1, 1);
      checkOutput("tout.busrqn", O_CPU_BUSRQn, 1'b1);
      checkOutput("tout.flag",   O_TIMEOUT,    1'b1);
      checkOutput("tout.hlda_seen", sawHlda,   1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1);
      checkOutput("tout.sticky", O_TIMEOUT, 1'b1);
      checkOutput("tout.idle",   O_BUSY,    1'b0);
      checkModel("tout.model");

      // Reset mid-grant: outputs must drop without a clock edge.
      doReset();
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 0);
      checkOutput("rstg.hlda_before", O_DMA_HLDA, 1'b1);
      @(negedge I_CLK);
      I_RST = 1'b1;
      #1;
      checkOutput("rstg.hlda",   O_DMA_HLDA,   1'b0);
      checkOutput("rstg.busrqn", O_CPU_BUSRQn, 1'b1);
      checkOutput("rstg.ram_a",  O_RAM_A,      I_CPU_A);
      modelReset();
      #1;
      I_RST = 1'b0;
      applyStimulus(1, 1, 1);
      applyStimulus(1, 1, 0);
      checkOutput("rstg.regrant", O_DMA_HLDA, 1'b1);
      checkModel("rstg.model");

      // Randomized traffic; the first segment enables only one clock in four.
      doReset();
      hrq = 0; ak = 1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(7) == 0) hrq = ~hrq;
         if ($urandom_range(2) == 0) ak = ~ak;
         en = (i < 1200) ? ((i % 4) == 0) : ($urandom_range(3) != 0);
         I_CPU_A   = 10'($urandom);
         I_DMA_AS  = 10'($urandom);
         I_CPU_CS  = 1'($urandom);
         I_DMA_CES = 1'($urandom);
         applyStimulus(en, hrq, ak);
         checkModel($sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
